// File: rtl/key_gen_pkg.sv
// Shared types and constants for the key bounce generator.
package key_gen_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_BNC = 2'd1,
    HOLD      = 2'd2,
    REL_BNC   = 2'd3
  } state_e;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Clock cycles per millisecond
  function automatic int unsigned ms_cycles(input int unsigned clk_freq);
    return clk_freq / 1000;
  endfunction

endpackage

// File: rtl/key_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left with feedback into bit 0, steps on adv_i.
import key_gen_pkg::*;

module key_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adv_i,
  output logic [15:0] q_o
);

  // advance once per segment load
  always_ff @(posedge clk_i) begin
    if (rst_i)      q_o <= SEED;
    else if (adv_i) q_o <= {q_o[14:0], ^(q_o & LFSR_TAPS)};
  end

endmodule

// File: rtl/key_bounce_gen.sv
// Bouncing key waveform generator: press bounce, clean hold, release bounce.
// Build option KEY_BOUNCE_LFSR_EN: pseudo-random bounce segment lengths from
// an LFSR; without it every segment is 2^(SEG_W-1) cycles.
import key_gen_pkg::*;

module key_bounce_gen #(
  parameter int unsigned CLK_FREQ       = 100000000,
  parameter logic        PRESS_LEVEL    = 1'b0,
  parameter int unsigned BOUNCE_TOGGLES = 6,
  parameter int unsigned SEG_W          = 12,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [15:0] hold_ms_i,
  output logic        key_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  edge_cnt_o
);

  localparam int unsigned MS_CYCLES  = ms_cycles(CLK_FREQ);
  localparam logic        IDLE_LEVEL = ~PRESS_LEVEL;
  localparam int          CW         = SEG_W + 1;
  localparam int          TW         = $clog2(BOUNCE_TOGGLES + 2);

  state_e          state_q, state_d;
  logic [CW-1:0]   seg_q, seg_d, seg_load;
  logic [TW-1:0]   tog_q, tog_d;
  logic [31:0]     hold_q, hold_d;
  logic            key_d, busy_d, done_d, adv, phase_end;
  logic [7:0]      ecnt_d;

`ifdef KEY_BOUNCE_LFSR_EN
  logic [15:0] lfsr_q;

  key_lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .adv_i (adv),
    .q_o   (lfsr_q)
  );

  assign seg_load = CW'(lfsr_q[SEG_W-1:0]) + CW'(1);
`else
  // Fixed-length segments; the advance strobe has no consumer here.
  wire unused_adv = adv;
  assign seg_load = CW'(1) << (SEG_W - 1);
`endif

  // next-state, waveform and status decode
  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    tog_d     = tog_q;
    hold_d    = hold_q;
    key_d     = key_o;
    busy_d    = busy_o;
    done_d    = 1'b0;
    adv       = 1'b0;
    phase_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = PRESS_BNC;
          key_d   = PRESS_LEVEL;
          busy_d  = 1'b1;
          seg_d   = seg_load;
          adv     = 1'b1;
          tog_d   = '0;
          hold_d  = 32'(hold_ms_i) * 32'(MS_CYCLES);
        end
      end
      PRESS_BNC, REL_BNC: begin
        if (BOUNCE_TOGGLES == 0) begin
          phase_end = 1'b1;
        end else if (seg_q == CW'(1)) begin
          key_d = ~key_o;
          tog_d = tog_q + TW'(1);
          seg_d = seg_load;
          adv   = 1'b1;
          // last toggle ends the phase on the same edge
          if (tog_q == TW'(BOUNCE_TOGGLES - 1)) phase_end = 1'b1;
        end else begin
          seg_d = seg_q - CW'(1);
        end
        if (phase_end) begin
          if (state_q == PRESS_BNC) begin
            state_d = HOLD;
            key_d   = PRESS_LEVEL;
          end else begin
            state_d = IDLE;
            key_d   = IDLE_LEVEL;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      HOLD: begin
        // zero or one remaining cycle: leave now with the release edge
        if (hold_q <= 32'd1) begin
          state_d = REL_BNC;
          key_d   = IDLE_LEVEL;
          seg_d   = seg_load;
          adv     = 1'b1;
          tog_d   = '0;
        end else begin
          hold_d = hold_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    ecnt_d = edge_cnt_o;
    if ((key_d != key_o) && (edge_cnt_o != 8'd255)) ecnt_d = edge_cnt_o + 8'd1;
  end

  // state and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      seg_q      <= '0;
      tog_q      <= '0;
      hold_q     <= '0;
      key_o      <= IDLE_LEVEL;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      edge_cnt_o <= '0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      tog_q      <= tog_d;
      hold_q     <= hold_d;
      key_o      <= key_d;
      busy_o     <= busy_d;
      done_o     <= done_d;
      edge_cnt_o <= ecnt_d;
    end
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Self-checking bench for key_bounce_gen: a timeline model predicts key/busy/done
// per cycle, a compare process checks every cycle, plus literal spot checks.
module tb_key_bounce_gen;

  localparam int BT   = 4;
  localparam int SEGW = 3;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] hold_ms = '0;
  logic        key, busy, done;
  logic [7:0]  ecnt;

  always #5 clk = ~clk;

  key_bounce_gen #(
    .CLK_FREQ(1000), .PRESS_LEVEL(1'b0), .BOUNCE_TOGGLES(BT),
    .SEG_W(SEGW), .SEED(16'hACE1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .hold_ms_i(hold_ms),
    .key_o(key), .busy_o(busy), .done_o(done), .edge_cnt_o(ecnt)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  int free_at = 0;
  int hold_at = 0, rel_at = 0;
  int done_seen = 0;
  int m_edge = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  bit exp_key [MAXC];
  bit exp_busy[MAXC];
  bit exp_done[MAXC];
  bit exp_rst [MAXC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reset at cycle c: everything idle from c+1, any scheduled sequence dropped.
  task automatic model_reset(input int c);
    for (int k = c + 1; k < MAXC; k++) begin
      exp_key[k] = 1'b1; exp_busy[k] = 1'b0; exp_done[k] = 1'b0;
    end
    if (c + 1 < MAXC) exp_rst[c+1] = 1'b1;
    m_lfsr  = 16'hACE1;
    free_at = c + 1;
  endtask

  // Accepted start at cycle c: lay out all edge times of the sequence.
  task automatic model_start(input int c, input int h);
    int segs[2*BT+2];
    int e[$];
    int t, d, j;
    bit lvl;
    for (int i = 0; i < 2*BT+2; i++) begin
`ifdef KEY_BOUNCE_LFSR_EN
      segs[i] = int'(m_lfsr[SEGW-1:0]) + 1;
      m_lfsr  = lfsr_step(m_lfsr);
`else
      segs[i] = 1 << (SEGW - 1);
`endif
    end
    t = c + 1;
    e.push_back(t);
    for (int i = 0; i < BT; i++) begin t += segs[i]; e.push_back(t); end
    if (BT == 0) t += 1;
    hold_at = t;
    t += (h > 0) ? h : 1;
    rel_at = t;
    e.push_back(t);
    for (int i = 0; i < BT; i++) begin t += segs[BT+1+i]; e.push_back(t); end
    if (BT == 0) t += 1;
    d = t;
    lvl = 1'b1;
    j = 0;
    for (int k = c + 1; k <= d && k < MAXC; k++) begin
      if (j < e.size() && e[j] == k) begin lvl = ~lvl; j++; end
      exp_key[k]  = lvl;
      exp_busy[k] = (k < d);
      exp_done[k] = (k == d);
    end
    free_at = d;
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Drive one cycle of inputs, inform the model, advance past the edge.
  task automatic step(input logic r, input logic s, input int h);
    rst = r; start = s; hold_ms = 16'(h);
    if (r) model_reset(cyc);
    else if (s && cyc >= free_at) model_start(cyc, h);
    @(posedge clk); #1;
    cyc++;
    if (cyc >= MAXC - 1) begin
      checks++; failures++;
      $display("FAIL cycle_budget cycle=%0d actual=over expected=under %0d", cyc, MAXC);
      finish_run();
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step(1'b0, 1'b0, 0);
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (exp_rst[cyc]) m_edge = 0;
    else if (cyc > 0 && exp_key[cyc] != exp_key[cyc-1] && m_edge < 255) m_edge++;
    if (done === 1'b1) done_seen++;
    chk("key_o", 32'(key), 32'(exp_key[cyc]));
    chk("busy_o", 32'(busy), 32'(exp_busy[cyc]));
    chk("done_o", 32'(done), 32'(exp_done[cyc]));
    chk("edge_cnt_o", 32'(ecnt), 32'(m_edge));
  end

  initial begin
    int d0;
    for (int k = 0; k < MAXC; k++) exp_key[k] = 1'b1;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    chk("rst_key", 32'(key), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_edge", 32'(ecnt), 32'd0);

    // fixed/lfsr press with hold 5, start at cycle 10
    run_to(10);
    step(1'b0, 1'b1, 5);
    chk("t1_fall11", 32'(key), 32'd0);
    chk("t1_busy11", 32'(busy), 32'd1);
`ifdef KEY_BOUNCE_LFSR_EN
    run_to(12); chk("t1_lfsr12", 32'(key), 32'd0);
    run_to(13); chk("t1_lfsr13", 32'(key), 32'd1);
    run_to(16); chk("t1_lfsr16", 32'(key), 32'd1);
    run_to(17); chk("t1_lfsr17", 32'(key), 32'd0);
    run_to(hold_at); chk("t1_press_settled", 32'(key), 32'd0);
`else
    run_to(14); chk("t1_k14", 32'(key), 32'd0);
    run_to(15); chk("t1_k15", 32'(key), 32'd1);
    run_to(19); chk("t1_k19", 32'(key), 32'd0);
    run_to(23); chk("t1_k23", 32'(key), 32'd1);
    run_to(27); chk("t1_k27", 32'(key), 32'd0);
    run_to(31); chk("t1_k31", 32'(key), 32'd0);
    run_to(32); chk("t1_rel32", 32'(key), 32'd1);
    run_to(47); chk("t1_busy47", 32'(busy), 32'd1);
    run_to(48); chk("t1_done48", 32'(done), 32'd1);
    chk("t1_busy48", 32'(busy), 32'd0);
    run_to(49); chk("t1_done49", 32'(done), 32'd0);
`endif
    run_to(free_at + 1);
    chk("t1_key_idle", 32'(key), 32'd1);
    chk("t1_edges", 32'(ecnt), 32'd10);
    chk("t1_dones", 32'(done_seen), 32'd1);

    // zero-length hold
    run_to(60);
    step(1'b0, 1'b1, 0);
`ifndef KEY_BOUNCE_LFSR_EN
    run_to(77); chk("t2_k77", 32'(key), 32'd0);
    run_to(78); chk("t2_rel78", 32'(key), 32'd1);
`endif
    run_to(free_at + 1);
    chk("t2_edges", 32'(ecnt), 32'd20);
    chk("t2_dones", 32'(done_seen), 32'd2);

    // starts during HOLD and REL_BNC ignored; start in done cycle accepted
    run_to(100);
    step(1'b0, 1'b1, 5);
    run_to(hold_at + 1);
    step(1'b0, 1'b1, 9);
    run_to(rel_at + 1);
    step(1'b0, 1'b1, 9);
    run_to(free_at);
    d0 = free_at;
`ifndef KEY_BOUNCE_LFSR_EN
    chk("t3_done_at138", 32'(d0), 32'd138);
`endif
    chk("t3_done_pulse", 32'(done), 32'd1);
    chk("t3_edges", 32'(ecnt), 32'd30);
    step(1'b0, 1'b1, 2);
    chk("t3_b2b_fall", 32'(key), 32'd0);
    chk("t3_b2b_busy", 32'(busy), 32'd1);
    run_to(free_at + 1);
    chk("t3_edges2", 32'(ecnt), 32'd40);
    chk("t3_dones", 32'(done_seen), 32'd4);

    // reset in the middle of the press bounce
    run_to(free_at + 5);
    step(1'b0, 1'b1, 3);
    step(1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    chk("t4_rst_key", 32'(key), 32'd1);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    chk("t4_rst_edge", 32'(ecnt), 32'd0);
    d0 = done_seen;
    run_to(cyc + 40);
    chk("t4_no_done", 32'(done_seen), 32'(d0));

    // 26 back-to-back sequences saturate the edge counter
    step(1'b0, 1'b1, 1);
    for (int i = 1; i <= 25; i++) begin
      run_to(free_at);
      if (i == 25) chk("t5_edges250", 32'(ecnt), 32'd250);
      step(1'b0, 1'b1, 1);
    end
    run_to(free_at + 1);
    chk("t5_sat", 32'(ecnt), 32'd255);
    step(1'b0, 1'b1, 0);
    run_to(free_at + 3);
    chk("t5_sat_hold", 32'(ecnt), 32'd255);
    chk("t5_key_idle", 32'(key), 32'd1);

    finish_run();
  end

endmodule
